// File: rtl/canny_pkg.sv
// Shared types for the Canny front end: window geometry, pixel/window types,
// gradient-stage region codes and the window buffer FSM states.
package canny_pkg;
    localparam int WIN   = 7;
    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [0:WIN-1][0:WIN-1] window_t;

    typedef enum logic [1:0] {
        GS_NONE     = 2'b00,
        GS_RIGHT    = 2'b01,
        GS_LEFT     = 2'b10,
        GS_INTERIOR = 2'b11
    } grad_shift_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN
    } state_t;
endpackage

// File: rtl/line_fifo.sv
// One image line of delay: dout is the pixel accepted DEPTH enables ago,
// i.e. the same column of the previous line.
module line_fifo #(
    parameter int DEPTH = 64,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);
    logic [DEPTH-1:0][PIX_W-1:0] taps;

    // Storage only; contents are overwritten before they can reach a valid window.
    always_ff @(posedge clk) begin
        if (en) taps <= {taps[DEPTH-2:0], din};
    end

    assign dout = taps[DEPTH-1];
endmodule

// File: rtl/window_buffer_7x7.sv
// Raster-stream to 7x7 window producer: six line delays feed a shifting
// register window, emitted with valid/ready plus the gradient region code.
module window_buffer_7x7 #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        frame_start,
    input  logic [PIX_W-1:0]            pix_in,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    output logic [0:6][0:6][PIX_W-1:0]  seven_buffer_out,
    output logic [1:0]                  grad_shift,
    output logic                        win_valid,
    input  logic                        win_ready,
    output logic                        frame_done
);
    import canny_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(WIN - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(WIN - 1);

    state_t                              state, state_d;
    logic [CW-1:0]                       col;
    logic [RW-1:0]                       row;
    logic [0:WIN-1][0:WIN-1][PIX_W-1:0]  win;
    grad_shift_t                         gs;
    logic [WIN-2:0][PIX_W-1:0]           lb_in, lb_out;
    logic                                accept, win_hs, last_pix, win_hit, frame_done_d;

    assign accept   = pix_valid && pix_ready;
    assign win_hs   = win_valid && win_ready;
    assign last_pix = (row == ROW_LAST) && (col == COL_LAST);
    assign win_hit  = (row >= ROW_FIRST) && (col >= COL_FIRST);

    // A restart pulse owns the cycle; the old frame's pixel is not taken.
    assign pix_ready = (state == ST_STREAM) && (!win_valid || win_ready) && !frame_start;

    assign lb_in[0] = pix_in;
    for (genvar k = 1; k < WIN - 1; k++) begin : g_chain
        assign lb_in[k] = lb_out[k-1];
    end

    for (genvar k = 0; k < WIN - 1; k++) begin : g_line
        line_fifo #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_line (
            .clk  (clk),
            .en   (accept),
            .din  (lb_in[k]),
            .dout (lb_out[k])
        );
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d      = state;
        frame_done_d = 1'b0;
        case (state)
            ST_IDLE:   if (frame_start) state_d = ST_STREAM;
            ST_STREAM: if (accept && last_pix) state_d = ST_DRAIN;
            ST_DRAIN:  if (win_hs) begin
                state_d      = ST_IDLE;
                frame_done_d = 1'b1;
            end
            default:   state_d = ST_IDLE;
        endcase
        if (frame_start) begin
            state_d      = ST_STREAM;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col        <= '0;
            row        <= '0;
            win        <= '0;
            gs         <= GS_NONE;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_done_d;
            if (frame_start) begin
                col       <= '0;
                row       <= '0;
                win_valid <= 1'b0;
                gs        <= GS_NONE;
            end else if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= last_pix ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                // Accept implies any pending window handshakes now, so just replace it.
                win_valid <= win_hit;
                gs <= !win_hit            ? GS_NONE :
                      (col == COL_FIRST)  ? GS_LEFT :
                      (col == COL_LAST)   ? GS_RIGHT : GS_INTERIOR;
            end else if (win_hs) begin
                win_valid <= 1'b0;
                gs        <= GS_NONE;
            end

            if (accept) begin
                for (int r = 0; r < WIN; r++) begin
                    for (int c = 0; c < WIN - 1; c++) win[r][c] <= win[r][c+1];
                end
                for (int r = 0; r < WIN - 1; r++) win[r][WIN-1] <= lb_out[WIN-2-r];
                win[WIN-1][WIN-1] <= pix_in;
            end
        end
    end

    assign seven_buffer_out = win;
    assign grad_shift       = gs;
endmodule
